pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised program-counter and fetch controller for the ARMv8 core front end.
//  Holds the architectural fetch PC and issues instruction-memory requests with a req/ack handshake.
//  Selects the next PC from three sources: sequential increment, branch redirect and exception vector.
//  Discards in-flight fetches that are squashed by a redirect, and delivers valid fetch PCs to decode.
// PARAMETERS
//  ADDR_W      64                         PC / address width in bits
//  RESET_VEC   64'h0000_0000_0000_0000    PC loaded on reset
//  EXC_VEC     64'h0000_0000_0000_0200    PC loaded on exception or misaligned target
//  INSTR_BYTES 4                          sequential increment; power of two
// PORTS
//  clk             in   1       clock; all state changes on the rising edge
//  reset           in   1       synchronous, active-high
//  stall           in   1       back-end stall; no new request is issued while high
//  br_taken        in   1       branch redirect strobe, one cycle
//  br_target       in   ADDR_W  branch target, sampled when br_taken=1
//  exc_req         in   1       exception redirect strobe, one cycle
//  imem_req        out  1       fetch request; held high until imem_ack
//  imem_addr       out  ADDR_W  fetch address; stable while imem_req=1 and imem_ack=0
//  imem_ack        in   1       memory accepted and returned the request (same cycle)
//  fetch_valid     out  1       one-cycle pulse: fetch_pc is a valid, non-squashed fetch
//  fetch_pc        out  ADDR_W  PC of the delivered fetch
//  pc              out  ADDR_W  current architectural fetch PC
//  misalign_fault  out  1       one-cycle pulse: br_target not INSTR_BYTES-aligned
// BEHAVIOUR
//  Reset: pc=RESET_VEC, state=S_IDLE, imem_req=0, imem_addr=RESET_VEC, fetch_valid=0,
//   fetch_pc=0, misalign_fault=0, pending redirect cleared.
//  Reset in any state abandons the outstanding request. An imem_ack arriving in S_IDLE is ignored.
//  Redirect priority: exc_req > br_taken > sequential.
//  Redirect target: EXC_VEC if exc_req=1; otherwise br_target.
//  br_target with low log2(INSTR_BYTES) bits nonzero: target becomes EXC_VEC and misalign_fault
//   pulses in the next cycle.
//  States:
//   S_IDLE: imem_req=0.
//    If stall=0: go to S_REQ next cycle with imem_addr=pc.
//    A redirect in S_IDLE loads pc=target next cycle. It is not a squash.
//   S_REQ: imem_req=1; imem_addr=pc; neither may change until imem_ack.
//    ack, no redirect: fetch_valid=1 and fetch_pc=pc next cycle; pc<=pc+INSTR_BYTES.
//     Stay in S_REQ (back-to-back) if stall=0, else go to S_IDLE.
//    ack and redirect in the same cycle: the fetch is squashed (no fetch_valid); pc<=target.
//     Go to S_REQ if stall=0, else S_IDLE.
//    redirect without ack: latch target into pending; go to S_DROP. imem_addr is held.
//   S_DROP: imem_req=1, address held.
//    A further exc_req overwrites pending. A further br_taken overwrites pending only if
//     pending is not an exception.
//    On ack: no fetch_valid; pc<=pending. Go to S_REQ if stall=0, else S_IDLE.
//  stall never drops imem_req while a request is outstanding (S_REQ/S_DROP); it only blocks
//   the next issue.
//  Latency: redirect to first request at the new target = 1 cycle in S_IDLE/S_REQ;
//   ack-wait + 1 cycle in S_DROP.
//  Increment wraps modulo 2^ADDR_W; no overflow flag.
//  fetch_valid and misalign_fault are single-cycle pulses; fetch_pc holds its last value
//   otherwise.
// TESTING
//  1 Reset, stall=0, imem_ack tied high -> imem_addr 0x0,0x4,0x8,0xC on consecutive cycles;
//    fetch_valid every cycle from cycle 2.
//  2 imem_ack delayed 3 cycles at 0x8 -> imem_addr holds 0x8 for all 3 cycles;
//    one fetch_valid with fetch_pc=0x8.
//  3 br_taken with target 0x100 while S_REQ at 0x10 without ack, ack 2 cycles later ->
//    no fetch_valid for 0x10; next imem_addr=0x100.
//  4 br_taken with target 0x100 and exc_req in the same cycle -> pc=EXC_VEC (0x200);
//    branch target never requested.
//  5 br_target=0x102 -> misalign_fault pulses once; next request at 0x200.
//  6 RESET_VEC=2^64-4, ack high -> requests at 0xFFFF_FFFF_FFFF_FFFC then 0x0;
//    reset asserted mid-request -> imem_req=0 next cycle, pc=RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller for the core front end.
// Issues req/ack fetches, handles branch/exception redirects and squashes stale fetches.
module pc_fetch_ctrl #(
  parameter int unsigned        ADDR_W      = 64,
  parameter logic [ADDR_W-1:0]  RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0]  EXC_VEC     = ADDR_W'('h200),
  parameter int unsigned        INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_req,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign_fault
);

  localparam logic [ADDR_W-1:0] INCR       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_imem_req;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic                r_fetch_valid;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic                r_misalign;
  logic [ADDR_W-1:0]   r_pend;
  logic                r_pend_exc;

  logic                w_misalign;
  logic                w_redirect;
  logic                w_tgt_is_exc;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_pend_take;
  logic [ADDR_W-1:0]   w_pend_nxt;
  logic                w_pend_exc_nxt;
  logic                w_fault_live;

  // A misaligned branch is turned into an exception-vector redirect.
  function automatic logic [ADDR_W-1:0] sel_target(input logic              exc,
                                                   input logic              bad_align,
                                                   input logic [ADDR_W-1:0] tgt);
    return (exc || bad_align) ? EXC_VEC : tgt;
  endfunction

  assign w_misalign   = br_taken & ~exc_req & (|(br_target & ALIGN_MASK));
  assign w_redirect   = exc_req | br_taken;
  assign w_tgt_is_exc = exc_req | w_misalign;
  assign w_target     = sel_target(exc_req, w_misalign, br_target);
  assign w_pc_inc     = r_pc + INCR;

  // While draining, a pending exception may only be displaced by another exception.
  assign w_pend_take    = exc_req | (br_taken & ~r_pend_exc);
  assign w_pend_nxt     = w_pend_take ? w_target : r_pend;
  assign w_pend_exc_nxt = w_pend_take ? w_tgt_is_exc : r_pend_exc;
  assign w_fault_live   = w_misalign & ~((r_state == S_DROP) & r_pend_exc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_VEC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_VEC;
      r_fetch_valid <= 1'b0;
      r_fetch_pc    <= '0;
      r_misalign    <= 1'b0;
      r_pend        <= '0;
      r_pend_exc    <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_misalign    <= w_fault_live;
      case (r_state)
        S_IDLE: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end
          r_imem_addr <= w_redirect ? w_target : r_pc;
          if (!stall) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            if (w_redirect) begin
              r_pc        <= w_target;
              r_imem_addr <= w_target;
            end else begin
              r_pc          <= w_pc_inc;
              r_imem_addr   <= w_pc_inc;
              r_fetch_valid <= 1'b1;
              r_fetch_pc    <= r_pc;
            end
            r_state    <= stall ? S_IDLE : S_REQ;
            r_imem_req <= ~stall;
          end else if (w_redirect) begin
            r_pend     <= w_target;
            r_pend_exc <= w_tgt_is_exc;
            r_state    <= S_DROP;
          end
        end
        S_DROP: begin
          r_pend     <= w_pend_nxt;
          r_pend_exc <= w_pend_exc_nxt;
          if (imem_ack) begin
            r_pc        <= w_pend_nxt;
            r_imem_addr <= w_pend_nxt;
            r_pend_exc  <= 1'b0;
            r_state     <= stall ? S_IDLE : S_REQ;
            r_imem_req  <= ~stall;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req       = r_imem_req;
  assign imem_addr      = r_imem_addr;
  assign fetch_valid    = r_fetch_valid;
  assign fetch_pc       = r_fetch_pc;
  assign pc             = r_pc;
  assign misalign_fault = r_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboarded bench for pc_fetch_ctrl: expected fetch PCs are queued as stimulus is driven
// and matched against fetch_valid pulses; a second instance covers the wrap/reset case.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, br_taken, exc_req, imem_ack;
  logic [63:0] br_target;
  logic        imem_req0, fetch_valid0, misalign0;
  logic [63:0] imem_addr0, fetch_pc0, pc0;

  logic        reset1, stall1, ack1, tie0;
  logic [63:0] tie0_addr;
  logic        imem_req1, fetch_valid1, misalign1;
  logic [63:0] imem_addr1, fetch_pc1, pc1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_unexp0 = 0;
  int n_unexp1 = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] exp0, exp1;

  pc_fetch_ctrl #(.ADDR_W(64), .RESET_VEC(64'h0), .EXC_VEC(64'h200), .INSTR_BYTES(4)) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .exc_req(exc_req), .imem_req(imem_req0), .imem_addr(imem_addr0), .imem_ack(imem_ack),
    .fetch_valid(fetch_valid0), .fetch_pc(fetch_pc0), .pc(pc0), .misalign_fault(misalign0)
  );

  pc_fetch_ctrl #(.ADDR_W(64), .RESET_VEC(64'hFFFF_FFFF_FFFF_FFFC), .EXC_VEC(64'h200),
                  .INSTR_BYTES(4)) u_dut1 (
    .clk(clk), .reset(reset1), .stall(stall1), .br_taken(tie0), .br_target(tie0_addr),
    .exc_req(tie0), .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(ack1),
    .fetch_valid(fetch_valid1), .fetch_pc(fetch_pc1), .pc(pc1), .misalign_fault(misalign1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (fetch_valid0) begin
      if (q0.size() == 0) n_unexp0++;
      else begin
        exp0 = q0.pop_front();
        check_val("fetch_pc0", fetch_pc0, exp0);
      end
    end
    if (fetch_valid1) begin
      if (q1.size() == 0) n_unexp1++;
      else begin
        exp1 = q1.pop_front();
        check_val("fetch_pc1", fetch_pc1, exp1);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; exc_req = 1'b0; imem_ack = 1'b0;
    br_target = '0;
    reset1 = 1'b1; stall1 = 1'b0; ack1 = 1'b0; tie0 = 1'b0; tie0_addr = '0;
    tick(); tick();

    // reset state
    check_val("rst_req",    64'(imem_req0), 64'h0);
    check_val("rst_addr",   imem_addr0, 64'h0);
    check_val("rst_fv",     64'(fetch_valid0), 64'h0);
    check_val("rst_fpc",    fetch_pc0, 64'h0);
    check_val("rst_pc",     pc0, 64'h0);
    check_val("rst_mis",    64'(misalign0), 64'h0);
    check_val("rst1_pc",    pc1, 64'hFFFF_FFFF_FFFF_FFFC);

    // 1: back-to-back sequential fetch with ack tied high
    reset = 1'b0; imem_ack = 1'b1;
    q0.push_back(64'h0); q0.push_back(64'h4); q0.push_back(64'h8);
    tick(); check_val("t1_addr0", imem_addr0, 64'h0); check_val("t1_req", 64'(imem_req0), 64'h1);
    tick(); check_val("t1_addr4", imem_addr0, 64'h4); check_val("t1_fv", 64'(fetch_valid0), 64'h1);
    tick(); check_val("t1_addr8", imem_addr0, 64'h8);
    imem_ack = 1'b0;

    // 2: ack delayed three cycles at 0x8
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t2_hold_addr", imem_addr0, 64'h8);
      check_val("t2_hold_req", 64'(imem_req0), 64'h1);
    end
    imem_ack = 1'b1; stall = 1'b1;
    tick();
    check_val("t2_fpc", fetch_pc0, 64'h8);
    check_val("t2_idle_req", 64'(imem_req0), 64'h0);
    check_val("t2_pc", pc0, 64'hC);

    // 3: branch while waiting at 0x10, ack two cycles later; ack in idle ignored
    stall = 1'b0; q0.push_back(64'hC);
    tick(); check_val("t3_addrC", imem_addr0, 64'hC); check_val("t3_idle_ack_fv", 64'(fetch_valid0), 64'h0);
    tick(); check_val("t3_addr10", imem_addr0, 64'h10);
    imem_ack = 1'b0; br_taken = 1'b1; br_target = 64'h100;
    tick(); br_taken = 1'b0;
    check_val("t3_drop_addr", imem_addr0, 64'h10); check_val("t3_drop_req", 64'(imem_req0), 64'h1);
    tick(); check_val("t3_drop_addr2", imem_addr0, 64'h10);
    imem_ack = 1'b1; q0.push_back(64'h100);
    tick();
    check_val("t3_new_addr", imem_addr0, 64'h100);
    check_val("t3_squash_fv", 64'(fetch_valid0), 64'h0);
    tick(); check_val("t3_addr104", imem_addr0, 64'h104);

    // 4: exception and branch together with ack: exception wins, fetch squashed
    br_taken = 1'b1; br_target = 64'h100; exc_req = 1'b1;
    tick(); br_taken = 1'b0; exc_req = 1'b0;
    check_val("t4_pc", pc0, 64'h200); check_val("t4_addr", imem_addr0, 64'h200);
    check_val("t4_fv", 64'(fetch_valid0), 64'h0);
    q0.push_back(64'h200); stall = 1'b1;
    tick(); imem_ack = 1'b0;
    check_val("t4_idle_req", 64'(imem_req0), 64'h0);

    // 4b: pending exception is not displaced by a later branch while draining
    stall = 1'b0;
    tick(); check_val("t4b_addr", imem_addr0, 64'h204);
    exc_req = 1'b1;
    tick(); exc_req = 1'b0; br_taken = 1'b1; br_target = 64'h400;
    tick(); br_taken = 1'b0; imem_ack = 1'b1; q0.push_back(64'h200);
    check_val("t4b_hold_addr", imem_addr0, 64'h204);
    tick(); check_val("t4b_addr_exc", imem_addr0, 64'h200); check_val("t4b_pc", pc0, 64'h200);
    tick(); imem_ack = 1'b0;

    // 5: misaligned branch target redirected to the exception vector
    br_taken = 1'b1; br_target = 64'h102; imem_ack = 1'b1;
    tick(); br_taken = 1'b0; stall = 1'b1;
    check_val("t5_mis", 64'(misalign0), 64'h1); check_val("t5_addr", imem_addr0, 64'h200);
    q0.push_back(64'h200);
    tick(); imem_ack = 1'b0;
    check_val("t5_mis_pulse", 64'(misalign0), 64'h0);

    // 6: PC wrap from the top of the address space, then reset mid-request
    reset1 = 1'b0; ack1 = 1'b1; q1.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    tick(); check_val("t6_addr_top", imem_addr1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("t6_req", 64'(imem_req1), 64'h1);
    tick(); check_val("t6_addr_wrap", imem_addr1, 64'h0); check_val("t6_pc_wrap", pc1, 64'h0);
    ack1 = 1'b0;
    tick(); check_val("t6_mid_req", 64'(imem_req1), 64'h1);
    reset1 = 1'b1;
    tick();
    check_val("t6_rst_req", 64'(imem_req1), 64'h0);
    check_val("t6_rst_pc", pc1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("t6_rst_addr", imem_addr1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();

    check_val("q0_left", 64'(q0.size()), 64'h0);
    check_val("q1_left", 64'(q1.size()), 64'h0);
    check_val("unexp_fetch0", 64'(n_unexp0), 64'h0);
    check_val("unexp_fetch1", 64'(n_unexp1), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
